ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. It is the sending counterpart of the existing PS/2 receive path.
- Sends one command byte at a time to the keyboard (for example 0xED LED set, 0xFF reset) over the shared open-drain PS2_CLK/PS2_DAT lines.
- Handles the inhibit/request-to-send sequence, clocks out data/parity/stop on device-generated clock edges, checks the device ACK, and reports done, NACK or timeout.
- Sits next to the receiver in the CLOCK_50 domain. busy_o gates the receiver while a transmit frame is in progress.

---
 rtl/ps2_host_tx.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts one byte
// plus odd parity and stop on device clock edges, then checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES       = 5000,
    parameter int unsigned DAT_SETUP_CYCLES     = 50,
    parameter int unsigned START_TIMEOUT_CYCLES = 750000,
    parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000
) (
    input  logic       CLOCK_50,
    input  logic       NRST,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_done_o,
    output logic       tx_nack_o,
    output logic       tx_timeout_o,
    output logic       busy_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_dat_oe_o,
    output logic [2:0] state_dbg_o
);

    localparam int unsigned MAX_A = (INHIBIT_CYCLES > DAT_SETUP_CYCLES) ? INHIBIT_CYCLES : DAT_SETUP_CYCLES;
    localparam int unsigned MAX_B = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ? START_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
    localparam int unsigned T_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int          TW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_WAIT_CLK  = 3'd3,
        S_SHIFT     = 3'd4,
        S_ACK       = 3'd5,
        S_IDLE_WAIT = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_q, parity_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          done_q, done_d;
    logic          nack_q, nack_d;
    logic          to_q, to_d;
    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    logic          fe;

    // Synchronisers reset to 1 so an idle (pulled-up) bus never looks like an edge.
    always_ff @(posedge CLOCK_50 or negedge NRST) begin
        if (!NRST) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_i;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_dat_i;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fe = clk_prev_q & ~clk_s2_q;

    always_ff @(posedge CLOCK_50 or negedge NRST) begin
        if (!NRST) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            parity_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            done_q    <= done_d;
            nack_q    <= nack_d;
            to_q      <= to_d;
        end
    end

    // Handshake: a byte is taken on any cycle where tx_valid_i && tx_ready_o;
    // tx_ready_o is high only in IDLE, so tx_valid_i is ignored while busy.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        nack_d    = 1'b0;
        to_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_valid_i) begin
                    shreg_d   = tx_data_i;
                    parity_d  = ~^tx_data_i;
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
                    timer_d  = '0;
                    dat_oe_d = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == TW'(DAT_SETUP_CYCLES - 1)) begin
                    timer_d  = '0;
                    clk_oe_d = 1'b0;
                    state_d  = S_WAIT_CLK;
                end
            end
            S_WAIT_CLK: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == TW'(START_TIMEOUT_CYCLES - 1)) begin
                    to_d     = 1'b1;
                    dat_oe_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (fe) begin
                    timer_d   = '0;
                    bit_cnt_d = 4'd1;
                    dat_oe_d  = ~shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT, S_ACK, S_IDLE_WAIT: begin
                timer_d = timer_q + 1'b1;
                // The transfer timeout takes priority over a same-cycle edge.
                if (timer_q == TW'(XFER_TIMEOUT_CYCLES - 1)) begin
                    to_d     = 1'b1;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (state_q == S_SHIFT) begin
                    if (fe) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q < 4'd8) begin
                            dat_oe_d = ~shreg_q[0];
                            shreg_d  = {1'b0, shreg_q[7:1]};
                        end else if (bit_cnt_q == 4'd8) begin
                            dat_oe_d = ~parity_q;
                        end else begin
                            dat_oe_d = 1'b0;
                            state_d  = S_ACK;
                        end
                    end
                end else if (state_q == S_ACK) begin
                    if (fe) begin
                        if (!dat_s2_q) begin
                            state_d = S_IDLE_WAIT;
                        end else begin
                            nack_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    if (clk_s2_q && dat_s2_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    assign tx_ready_o   = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign tx_done_o    = done_q;
    assign tx_nack_o    = nack_q;
    assign tx_timeout_o = to_q;
    assign ps2_clk_oe_o = clk_oe_q;
    assign ps2_dat_oe_o = dat_oe_q;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device model clocks frames on a wired-AND bus; a vector
// table covers the normal/parity/NACK frames, hand sequences cover timeouts and reset.
module tb_ps2_host_tx;

    localparam int INH      = 50;
    localparam int SETUP    = 10;
    localparam int START_TO = 2000;
    localparam int XFER_TO  = 1500;
    localparam int H        = 20;
    localparam int RES_DONE = 0;
    localparam int RES_NACK = 1;

    logic       CLOCK_50 = 1'b0;
    logic       NRST;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o, tx_done_o, tx_nack_o, tx_timeout_o, busy_o;
    logic       ps2_clk_i, ps2_dat_i, ps2_clk_oe_o, ps2_dat_oe_o;
    logic [2:0] state_dbg_o;
    logic       dev_clk_low, dev_dat_low;

    assign ps2_clk_i = ~(ps2_clk_oe_o | dev_clk_low);
    assign ps2_dat_i = ~(ps2_dat_oe_o | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES      (INH),
        .DAT_SETUP_CYCLES    (SETUP),
        .START_TIMEOUT_CYCLES(START_TO),
        .XFER_TIMEOUT_CYCLES (XFER_TO)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .NRST        (NRST),
        .tx_data_i   (tx_data_i),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .tx_done_o   (tx_done_o),
        .tx_nack_o   (tx_nack_o),
        .tx_timeout_o(tx_timeout_o),
        .busy_o      (busy_o),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_dat_i   (ps2_dat_i),
        .ps2_clk_oe_o(ps2_clk_oe_o),
        .ps2_dat_oe_o(ps2_dat_oe_o),
        .state_dbg_o (state_dbg_o)
    );

    // Clock / watchdog
    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // Monitors
    int cyc = 0, done_cnt = 0, nack_cnt = 0, to_cnt = 0, acc_cnt = 0;
    always @(posedge CLOCK_50) begin
        cyc++;
        if (tx_done_o)                 done_cnt++;
        if (tx_nack_o)                 nack_cnt++;
        if (tx_timeout_o)              to_cnt++;
        if (tx_valid_i && tx_ready_o)  acc_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic clear_counts();
        @(negedge CLOCK_50);
        done_cnt = 0; nack_cnt = 0; to_cnt = 0; acc_cnt = 0;
    endtask

    // Driver: accept a byte (valid held high with changing data through the request
    // phase), measure inhibit/request lengths, then clock n_edges device clocks.
    task automatic send_frame(input logic [7:0] data, input bit ack, input int n_edges,
                              output logic [9:0] got, output int inh_len, output int req_len,
                              output int t_fe1);
        got   = '0;
        t_fe1 = 0;
        @(negedge CLOCK_50);
        tx_data_i  = data;
        tx_valid_i = 1'b1;
        @(negedge CLOCK_50);
        tx_data_i = ~data;
        inh_len = 0;
        while (ps2_clk_oe_o && !ps2_dat_oe_o && inh_len < 10000) begin
            inh_len++;
            @(negedge CLOCK_50);
        end
        req_len = 0;
        while (ps2_clk_oe_o && ps2_dat_oe_o && req_len < 10000) begin
            req_len++;
            @(negedge CLOCK_50);
        end
        tx_valid_i = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        for (int i = 1; i <= n_edges; i++) begin
            if (i == 1) t_fe1 = cyc;
            dev_clk_low = 1'b1;
            repeat (H) @(negedge CLOCK_50);
            dev_clk_low = 1'b0;
            if (i <= 10) got[i-1] = ps2_dat_i;
            if (i == 10 && ack) dev_dat_low = 1'b1;
            repeat (H) @(negedge CLOCK_50);
        end
        dev_dat_low = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic       exp_par;
        int         exp_res;
    } vec_t;

    task automatic run_vec(input vec_t v);
        logic [9:0] got;
        int inh, req, t1;
        clear_counts();
        send_frame(v.data, v.ack, 11, got, inh, req, t1);
        repeat (5) @(negedge CLOCK_50);
        check($sformatf("inhibit_len_%02h", v.data), inh, INH);
        check($sformatf("req_len_%02h", v.data), req, SETUP);
        check($sformatf("data_bits_%02h", v.data), got[7:0], v.data);
        check($sformatf("parity_%02h", v.data), got[8], v.exp_par);
        check($sformatf("stop_%02h", v.data), got[9], 1'b1);
        check($sformatf("done_cnt_%02h", v.data), done_cnt, (v.exp_res == RES_DONE) ? 1 : 0);
        check($sformatf("nack_cnt_%02h", v.data), nack_cnt, (v.exp_res == RES_NACK) ? 1 : 0);
        check($sformatf("to_cnt_%02h", v.data), to_cnt, 0);
        check($sformatf("accept_cnt_%02h", v.data), acc_cnt, 1);
        check($sformatf("busy_after_%02h", v.data), busy_o, 1'b0);
        check($sformatf("ready_after_%02h", v.data), tx_ready_o, 1'b1);
        check($sformatf("clk_oe_after_%02h", v.data), ps2_clk_oe_o, 1'b0);
        check($sformatf("dat_oe_after_%02h", v.data), ps2_dat_oe_o, 1'b0);
    endtask

    vec_t vecs[5];
    vec_t v_after;

    initial begin
        logic [9:0] got;
        int inh, req, t1, n;

        vecs[0] = '{8'hED, 1'b1, 1'b1, RES_DONE};
        vecs[1] = '{8'h01, 1'b1, 1'b0, RES_DONE};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, RES_DONE};
        vecs[3] = '{8'h00, 1'b1, 1'b1, RES_DONE};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, RES_NACK};
        v_after = '{8'h3C, 1'b1, 1'b1, RES_DONE};

        NRST = 1'b0; tx_data_i = '0; tx_valid_i = 1'b0;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_ready", tx_ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_clk_oe", ps2_clk_oe_o, 1'b0);
        check("rst_dat_oe", ps2_dat_oe_o, 1'b0);
        check("rst_pulses", {tx_done_o, tx_nack_o, tx_timeout_o}, 3'b000);
        NRST = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Start timeout: device never clocks.
        clear_counts();
        tx_data_i = 8'h55; tx_valid_i = 1'b1;
        @(negedge CLOCK_50);
        tx_valid_i = 1'b0;
        n = 0;
        while (!tx_timeout_o && n < INH + SETUP + START_TO + 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        check_range("start_timeout_latency", n, INH + SETUP + START_TO - 3, INH + SETUP + START_TO + 3);
        @(negedge CLOCK_50);
        check("start_to_ready", tx_ready_o, 1'b1);
        check("start_to_oe", {ps2_clk_oe_o, ps2_dat_oe_o}, 2'b00);
        repeat (3) @(negedge CLOCK_50);
        check("start_to_cnt", to_cnt, 1);
        check("start_to_done", done_cnt, 0);

        // Transfer stall after bit 4.
        clear_counts();
        send_frame(8'h96, 1'b1, 4, got, inh, req, t1);
        n = 0;
        while (!tx_timeout_o && n < XFER_TO + 200) begin
            @(negedge CLOCK_50);
            n++;
        end
        check_range("xfer_timeout_latency", cyc - t1, XFER_TO - 3, XFER_TO + 3);
        @(negedge CLOCK_50);
        check("xfer_to_oe", {ps2_clk_oe_o, ps2_dat_oe_o}, 2'b00);
        check("xfer_to_ready", tx_ready_o, 1'b1);
        repeat (3) @(negedge CLOCK_50);
        check("xfer_to_cnt", to_cnt, 1);
        check("xfer_to_done", done_cnt + nack_cnt, 0);
        run_vec(v_after);

        // Async reset mid-frame (bit 4 of 0xC3 is 0, so data is being driven low).
        clear_counts();
        send_frame(8'hC3, 1'b1, 5, got, inh, req, t1);
        check("pre_reset_busy", busy_o, 1'b1);
        check("pre_reset_dat_oe", ps2_dat_oe_o, 1'b1);
        #3 NRST = 1'b0;
        #1;
        check("reset_mid_oe", {ps2_clk_oe_o, ps2_dat_oe_o}, 2'b00);
        check("reset_mid_busy", busy_o, 1'b0);
        check("reset_mid_ready", tx_ready_o, 1'b1);
        @(negedge CLOCK_50);
        NRST = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        run_vec(v_after);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
